// File: rtl/text_lcd_pkg.sv
// text_lcd_pkg: shared constants and state types for the HD44780 controller.
// Holds LCD command bytes, ASCII helpers and the FSM/slot enums.
package text_lcd_pkg;

  localparam logic [7:0] FUNC_SET   = 8'h38;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] ENTRY      = 8'h06;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] LINE1_ADDR = 8'h80;
  localparam logic [7:0] LINE2_ADDR = 8'hC0;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;

  typedef enum logic [2:0] {
    S_PWR,
    S_INIT,
    S_IDLE,
    S_ADDR1,
    S_DATA1,
    S_ADDR2,
    S_DATA2
  } state_t;

  typedef enum logic [1:0] {
    P_SETUP,
    P_PULSE,
    P_WAIT,
    P_DONE
  } phase_t;

  function automatic logic [7:0] init_cmd(
    input logic [1:0] i
  );
    logic [7:0] c;
    case (i)
      2'd0:    c = FUNC_SET;
      2'd1:    c = DISP_ON;
      2'd2:    c = ENTRY;
      default: c = CLEAR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/text_lcd_ctrl_bin2bcd.sv
// lcd_bin2bcd: serial double-dabble converter, one input bit per clock.
// Used by text_lcd_ctrl only when TEXT_LCD_NUM_FIELD_EN is defined.
module lcd_bin2bcd #(
  parameter int VAL_W      = 8,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VAL_W-1:0]        bin,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf
);

  // Enough digits for the full input range so overflow is detectable.
  localparam int FD_MIN = (VAL_W * 31) / 100 + 1;
  localparam int FD = (FD_MIN > NUM_DIGITS) ? FD_MIN : NUM_DIGITS;
  localparam int CW = $clog2(VAL_W + 1);

  logic [4*FD-1:0]  acc_q;
  logic [4*FD-1:0]  acc_adj;
  logic [VAL_W-1:0] sh_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;

  // Add 3 to every digit that would overflow on the next shift.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < FD; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // Load on start, then shift one bit per cycle for VAL_W cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      acc_q  <= '0;
      sh_q   <= bin;
      cnt_q  <= CW'(VAL_W);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      {acc_q, sh_q} <= {acc_adj, sh_q} << 1;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign done = done_q;
  assign bcd  = acc_q[4*NUM_DIGITS-1:0];

  generate
    if (FD > NUM_DIGITS) begin : g_ovf
      assign ovf = |acc_q[4*FD-1:4*NUM_DIGITS];
    end else begin : g_no_ovf
      assign ovf = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/text_lcd_ctrl.sv
// text_lcd_ctrl: 2-line HD44780 controller, init + full-frame rewrite.
// Define TEXT_LCD_NUM_FIELD_EN to overlay a decimal field on line 2.
module text_lcd_ctrl #(
  parameter int NUM_COLS       = 16,
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100000,
  parameter int POWERUP_CYC    = 1000000,
  parameter int VAL_W          = 8,
  parameter int NUM_DIGITS     = 3,
  parameter int NUM_COL        = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*NUM_COLS-1:0] line1,
  input  logic [8*NUM_COLS-1:0] line2,
  input  logic [VAL_W-1:0]      val,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  output logic                  init_done,
  output logic                  frame_done,
  output logic                  LCD_E,
  output logic                  LCD_RS,
  output logic                  LCD_RW,
  output logic [7:0]            LCD_DATA
);

  import text_lcd_pkg::*;

  localparam logic [31:0] PWR_LAST = 32'(POWERUP_CYC - 1);
  localparam logic [31:0] E_LAST   = 32'(E_PULSE_CYC - 1);
  localparam logic [31:0] CMD_LAST = 32'(CMD_WAIT_CYC - 1);
  localparam logic [31:0] CLR_LAST = 32'(CLEAR_WAIT_CYC - 1);
  localparam logic [7:0]  COL_LAST = 8'(NUM_COLS - 1);

  state_t state_q, state_d;
  phase_t ph_q, ph_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic        init_q, init_d;

  logic [8*NUM_COLS-1:0] sh1_q, sh2_q;
  logic        accept;
  logic        conv_done;
  logic        last_col;
  logic [31:0] wait_last;
  logic [7:0]  ch1, ch2;

  assign accept   = (state_q == S_IDLE) && upd_valid;
  assign last_col = (idx_q == COL_LAST);

`ifdef TEXT_LCD_NUM_FIELD_EN
  logic [4*NUM_DIGITS-1:0] bcd;
  logic                    bcd_ovf;
  logic                    bcd_done;
  logic [8*NUM_DIGITS-1:0] fld;
  logic                    lead;
  logic [3:0]              dg;

  lcd_bin2bcd #(
    .VAL_W      (VAL_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .bin   (val),
    .done  (bcd_done),
    .bcd   (bcd),
    .ovf   (bcd_ovf)
  );

  assign conv_done = bcd_done;

  // Digits to ASCII with leading-zero blanking; last digit always shown.
  always_comb begin
    fld  = '0;
    lead = 1'b1;
    dg   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dg = bcd[4*(NUM_DIGITS-1-i) +: 4];
      if (dg != 4'd0 || i == NUM_DIGITS - 1)
        lead = 1'b0;
      if (bcd_ovf)
        fld[8*(NUM_DIGITS-1-i) +: 8] = ASCII_STAR;
      else if (lead)
        fld[8*(NUM_DIGITS-1-i) +: 8] = ASCII_SPACE;
      else
        fld[8*(NUM_DIGITS-1-i) +: 8] = ASCII_ZERO + {4'd0, dg};
    end
  end
`else
  logic unused_val;
  assign unused_val = ^val;
  assign conv_done  = 1'b1;
`endif

  // Character for the current column of each shadow line.
  always_comb begin
    ch1 = sh1_q[8*(NUM_COLS-1-int'(idx_q)) +: 8];
    ch2 = sh2_q[8*(NUM_COLS-1-int'(idx_q)) +: 8];
`ifdef TEXT_LCD_NUM_FIELD_EN
    if (int'(idx_q) >= NUM_COL &&
        int'(idx_q) < NUM_COL + NUM_DIGITS)
      ch2 = fld[8*(NUM_DIGITS-1-(int'(idx_q)-NUM_COL)) +: 8];
`endif
  end

  // Sequencer state and slot-timing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_PWR;
      ph_q    <= P_SETUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      init_q  <= init_d;
    end
  end

  // Shadow buffers capture the inputs only on the accept cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh1_q <= {NUM_COLS{ASCII_SPACE}};
      sh2_q <= {NUM_COLS{ASCII_SPACE}};
    end else if (accept) begin
      sh1_q <= line1;
      sh2_q <= line2;
    end
  end

  // Next state: power-up delay, then setup/pulse/wait slots per byte.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    init_d  = init_q;
    if (state_q == S_INIT && idx_q == 8'd3)
      wait_last = CLR_LAST;
    else
      wait_last = CMD_LAST;
    unique case (state_q)
      S_PWR: begin
        if (cnt_q == PWR_LAST) begin
          state_d = S_INIT;
          ph_d    = P_SETUP;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_IDLE: begin
        if (accept) begin
          state_d = S_ADDR1;
          ph_d    = P_SETUP;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_INIT, S_ADDR1, S_DATA1, S_ADDR2, S_DATA2: begin
        unique case (ph_q)
          P_SETUP: begin
            if (state_q != S_ADDR2 || conv_done) begin
              ph_d  = P_PULSE;
              cnt_d = '0;
            end
          end
          P_PULSE: begin
            if (cnt_q == E_LAST) begin
              ph_d  = P_WAIT;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
          P_WAIT: begin
            if (cnt_q == wait_last) begin
              ph_d  = P_SETUP;
              cnt_d = '0;
              unique case (state_q)
                S_INIT: begin
                  if (idx_q == 8'd3) begin
                    state_d = S_IDLE;
                    init_d  = 1'b1;
                    idx_d   = '0;
                  end else begin
                    idx_d = idx_q + 8'd1;
                  end
                end
                S_ADDR1: begin
                  state_d = S_DATA1;
                  idx_d   = '0;
                end
                S_DATA1: begin
                  if (last_col) begin
                    state_d = S_ADDR2;
                    idx_d   = '0;
                  end else begin
                    idx_d = idx_q + 8'd1;
                  end
                end
                S_ADDR2: begin
                  state_d = S_DATA2;
                  idx_d   = '0;
                end
                S_DATA2: begin
                  if (last_col)
                    ph_d = P_DONE;
                  else
                    idx_d = idx_q + 8'd1;
                end
                default: ;
              endcase
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
          P_DONE: begin
            state_d = S_IDLE;
            ph_d    = P_SETUP;
            idx_d   = '0;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Bus byte and register-select for the slot in progress.
  always_comb begin
    LCD_RS   = 1'b0;
    LCD_DATA = 8'h00;
    unique case (1'b1)
      (state_q == S_INIT):  LCD_DATA = init_cmd(idx_q[1:0]);
      (state_q == S_ADDR1): LCD_DATA = LINE1_ADDR;
      (state_q == S_DATA1): begin
        LCD_RS   = 1'b1;
        LCD_DATA = ch1;
      end
      (state_q == S_ADDR2): LCD_DATA = LINE2_ADDR;
      (state_q == S_DATA2): begin
        LCD_RS   = 1'b1;
        LCD_DATA = ch2;
      end
      default: ;
    endcase
  end

  assign LCD_E      = (ph_q == P_PULSE);
  assign LCD_RW     = 1'b0;
  assign frame_done = (ph_q == P_DONE);
  assign upd_ready  = (state_q == S_IDLE);
  assign init_done  = init_q;

endmodule

// File: tb/tb_text_lcd_ctrl.sv
// tb_text_lcd_ctrl: directed bench for text_lcd_ctrl with short timing.
// Checks init, frame bytes/timing, hold-off, reset abort, numeric field.
module tb_text_lcd_ctrl;

  localparam int NC   = 4;
  localparam int EP   = 2;
  localparam int CWT  = 4;
  localparam int CLW  = 8;
  localparam int PW   = 20;
  localparam int VW   = 8;
  localparam int ND   = 2;
  localparam int NCOL = 2;

`ifdef TEXT_LCD_NUM_FIELD_EN
  localparam logic [7:0]  F1C2 = 8'h20;
  localparam logic [7:0]  F1C3 = 8'h37;
  localparam logic [31:0] E2A  = "ij**";
  localparam logic [31:0] E2B  = "RR 0";
`else
  localparam logic [7:0]  F1C2 = 8'h79;
  localparam logic [7:0]  F1C3 = 8'h7A;
  localparam logic [31:0] E2A  = "ijkl";
  localparam logic [31:0] E2B  = "RRRR";
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [8*NC-1:0] line1 = '0;
  logic [8*NC-1:0] line2 = '0;
  logic [VW-1:0]   val = '0;
  logic upd_valid = 1'b0;
  logic upd_ready, init_done, frame_done;
  logic LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int unstable = 0;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         gap;
  } vec_t;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         rise;
    int         fall;
  } wr_t;

  vec_t vec [14];
  vec_t exp_q [$];
  wr_t  q [$];
  wr_t  cur;
  logic e_prev = 1'b0;

  text_lcd_ctrl #(
    .NUM_COLS       (NC),
    .E_PULSE_CYC    (EP),
    .CMD_WAIT_CYC   (CWT),
    .CLEAR_WAIT_CYC (CLW),
    .POWERUP_CYC    (PW),
    .VAL_W          (VW),
    .NUM_DIGITS     (ND),
    .NUM_COL        (NCOL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .line1      (line1),
    .line2      (line2),
    .val        (val),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .init_done  (init_done),
    .frame_done (frame_done),
    .LCD_E      (LCD_E),
    .LCD_RS     (LCD_RS),
    .LCD_RW     (LCD_RW),
    .LCD_DATA   (LCD_DATA)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every E pulse with its byte and edge times.
  always @(negedge clk) begin
    if (LCD_E && !e_prev) begin
      cur.rs   = LCD_RS;
      cur.d    = LCD_DATA;
      cur.rise = cyc;
    end else if (LCD_E &&
                 (LCD_RS !== cur.rs || LCD_DATA !== cur.d)) begin
      unstable++;
    end
    if (!LCD_E && e_prev) begin
      cur.fall = cyc;
      q.push_back(cur);
    end
    e_prev = LCD_E;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_q(input string nm, input int t_end);
    int nxt;
    chk({nm, "_count"}, q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= q.size()) break;
      if (i == exp_q.size() - 1)
        nxt = t_end;
      else
        nxt = q[i+1].rise;
      chk($sformatf("%s_rs%0d", nm, i), q[i].rs, exp_q[i].rs);
      chk($sformatf("%s_d%0d", nm, i), q[i].d, exp_q[i].d);
      chk($sformatf("%s_w%0d", nm, i),
          q[i].fall - q[i].rise, EP);
      chk($sformatf("%s_gap%0d", nm, i),
          nxt - q[i].fall, exp_q[i].gap);
    end
  endtask

  task automatic push_text(input logic [8*NC-1:0] l1,
                           input logic [8*NC-1:0] l2);
    exp_q.delete();
    exp_q.push_back('{1'b0, 8'h80, 5});
    for (int c = 0; c < NC; c++)
      exp_q.push_back('{1'b1, l1[8*(NC-1-c) +: 8], 5});
    exp_q.push_back('{1'b0, 8'hC0, 5});
    for (int c = 0; c < NC; c++)
      exp_q.push_back('{1'b1, l2[8*(NC-1-c) +: 8],
                        (c == NC - 1) ? 4 : 5});
  endtask

  task automatic wait_fd(output int t);
    int n;
    n = 0;
    while (!frame_done && n < 300) begin
      tick();
      n++;
    end
    chk("frame_done_timeout", n < 300, 1);
    t = cyc;
  endtask

  task automatic do_init();
    int t0, n, td;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_E", LCD_E, 0);
    chk("rst_RS", LCD_RS, 0);
    chk("rst_RW", LCD_RW, 0);
    chk("rst_DATA", LCD_DATA, 8'h00);
    chk("rst_ready", upd_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    t0 = cyc;
    q.delete();
    n = 0;
    while (!init_done && n < 300) begin
      tick();
      n++;
    end
    chk("init_timeout", n < 300, 1);
    td = cyc;
    chk("init_ready", upd_ready, 1);
    chk("pwr_first_rise", q.size() > 0 ? q[0].rise - t0 : -1,
        PW + 1);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(vec[i]);
    check_q("init", td);
  endtask

  initial begin : main
    int ta, tf, tf2, n;

    vec = '{
      '{1'b0, 8'h38, 5}, '{1'b0, 8'h0C, 5},
      '{1'b0, 8'h06, 5}, '{1'b0, 8'h01, CLW},
      '{1'b0, 8'h80, 5},
      '{1'b1, 8'h41, 5}, '{1'b1, 8'h42, 5},
      '{1'b1, 8'h43, 5}, '{1'b1, 8'h44, 5},
      '{1'b0, 8'hC0, 5},
      '{1'b1, 8'h77, 5}, '{1'b1, 8'h78, 5},
      '{1'b1, F1C2, 5},  '{1'b1, F1C3, 4}
    };

    do_init();

    // Frame 1: plain update, table-driven byte check.
    q.delete();
    line1 = "ABCD";
    line2 = "wxyz";
    val = 8'd7;
    upd_valid = 1'b1;
    tick();
    ta = cyc;
    upd_valid = 1'b0;
    chk("f1_ready_low", upd_ready, 0);
    wait_fd(tf);
    chk("f1_latency", tf - ta, 70);
    chk("f1_ready_at_done", upd_ready, 0);
    chk("f1_first_rise", q.size() > 0 ? q[0].rise - ta : -1, 1);
    exp_q.delete();
    for (int i = 4; i < 14; i++) exp_q.push_back(vec[i]);
    check_q("f1", tf);
    tick();
    chk("f1_done_pulse", frame_done, 0);
    chk("f1_ready_after", upd_ready, 1);

    // Frame 2: valid held, inputs changed mid-frame.
    q.delete();
    line1 = "EFGH";
    line2 = "ijkl";
    val = 8'd123;
    upd_valid = 1'b1;
    tick();
    ta = cyc;
    line1 = "QQQQ";
    line2 = "RRRR";
    val = 8'd0;
    wait_fd(tf);
    chk("f2_latency", tf - ta, 70);
    chk("f2_ready_at_done", upd_ready, 0);
    push_text("EFGH", E2A);
    check_q("f2", tf);
    q.delete();
    tick();
    chk("f2_ready_after", upd_ready, 1);
    tick();
    upd_valid = 1'b0;
    wait_fd(tf2);
    chk("f3_latency", tf2 - tf, 72);
    chk("f3_first_rise", q.size() > 0 ? q[0].rise - tf : -1, 3);
    push_text("QQQQ", E2B);
    check_q("f3", tf2);
    tick();

    // Reset during the third data byte's E pulse.
    q.delete();
    line1 = "MNOP";
    line2 = "stuv";
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    n = 0;
    while (!(LCD_E && q.size() == 3) && n < 300) begin
      tick();
      n++;
    end
    chk("abort_reach_timeout", n < 300, 1);
    chk("abort_byte", LCD_DATA, 8'h4F);
    chk("abort_rs", LCD_RS, 1);
    rst = 1'b1;
    tick();
    chk("abort_E", LCD_E, 0);
    chk("abort_init_done", init_done, 0);
    chk("abort_ready", upd_ready, 0);
    do_init();

    chk("rs_data_stable", unstable, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_lcd_ctrl.md
Name: text_lcd_ctrl

Overview:
- Parametrised HD44780-class 2-line character LCD controller, 8-bit write-only bus.
- Runs the power-up init sequence, then rewrites both lines from shadow buffers on each accepted update.
- Produces proper E pulse and command timing from parameters.
- Generalises the fixed-text/3-digit display: configurable width and timing, valid/ready update handshake, and an optional numeric field.

Parameters:
- NUM_COLS, 16, characters per line (1..40).
- E_PULSE_CYC, 25, clk cycles E held high per write (≥1).
- CMD_WAIT_CYC, 2500, clk cycles E low after each non-clear write (≥1).
- CLEAR_WAIT_CYC, 100000, clk cycles E low after CLEAR (≥1).
- POWERUP_CYC, 1000000, clk cycles idle after reset before first command (≥1).
- VAL_W, 8, width of numeric input.
- NUM_DIGITS, 3, decimal digits shown in numeric field.
- NUM_COL, 13, line-2 column of leftmost digit (NUM_COL+NUM_DIGITS ≤ NUM_COLS).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- line1  in  8*NUM_COLS  line-1 text, ASCII; [8*NUM_COLS-1 -: 8] is column 0.
- line2  in  8*NUM_COLS  line-2 text, same packing.
- val  in  VAL_W  unsigned value for numeric field; ignored when feature is off.
- upd_valid  in  1  request to display line1/line2/val.
- upd_ready  out  1  high when an update can be accepted.
- init_done  out  1  high once init sequence completes; stays high until reset.
- frame_done  out  1  one-cycle pulse after last character of line 2 finishes its wait.
- LCD_E  out  1  enable strobe.
- LCD_RS  out  1  0 = command, 1 = data.
- LCD_RW  out  1  tied 0 (write only).
- LCD_DATA  out  8  bus data.

Behaviour:
- Reset (one clk, active-high, synchronous) sets:
  - State: S_PWR, counters 0, buffers to ASCII space.
  - Outputs: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=8'h00, upd_ready=0, init_done=0, frame_done=0.
- Reset mid-write aborts immediately, drops E the next cycle, and restarts from S_PWR.
- Write slot, identical for every byte:
  - 1 setup cycle: E=0, RS/DATA driven.
  - E_PULSE_CYC cycles: E=1.
  - Wait cycles: E=0; CMD_WAIT_CYC, or CLEAR_WAIT_CYC for CLEAR.
  - RS/DATA are held stable through the entire slot.
- State sequence:
  - S_PWR: count POWERUP_CYC, then S_INIT.
  - S_INIT: write FUNC_SET 8'h38, DISP_ON 8'h0C, ENTRY 8'h06, CLEAR 8'h01 in order; then init_done=1 and go to S_IDLE.
  - S_IDLE: upd_ready=1; on upd_valid&&upd_ready, latch line1/line2/val into shadow buffers that cycle, drop upd_ready, go to S_ADDR1.
  - S_ADDR1: write 8'h80, then S_DATA1.
  - S_DATA1: write NUM_COLS data bytes, column 0 first; then S_ADDR2.
  - S_ADDR2: write 8'hC0, then S_DATA2.
  - S_DATA2: write NUM_COLS data bytes; after the last wait, pulse frame_done and go to S_IDLE.
- An upd_valid arriving during init or a frame is held off by upd_ready=0; inputs are never sampled outside the accept cycle.
- Frame timing: (2+2*NUM_COLS) × (1+E_PULSE_CYC+CMD_WAIT_CYC) cycles from accept to frame_done.
- upd_ready returns high the cycle after frame_done.

Optional Feature:
- Macro: TEXT_LCD_NUM_FIELD_EN.
- Defined:
  - On accept, val is converted to BCD serially in VAL_W cycles (double-dabble).
  - Line-2 columns NUM_COL..NUM_COL+NUM_DIGITS-1 are overridden with the digits, right-aligned.
  - Leading zeros become spaces; the last digit always shows ('0' for 0).
  - If val ≥ 10^NUM_DIGITS, the field shows all '*'.
  - Conversion is guaranteed complete before S_ADDR2; the FSM stalls in S_ADDR2 setup until done.
- Undefined: val is ignored, no converter is instantiated, line2 is shown verbatim.

Decomposition:
- Package text_lcd_pkg holds:
  - Command constants: FUNC_SET, DISP_ON, ENTRY, CLEAR, LINE1_ADDR, LINE2_ADDR.
  - State enum.
  - ASCII_SPACE, ASCII_ZERO, ASCII_STAR.
- One sub-module, lcd_bin2bcd (VAL_W, NUM_DIGITS):
  - Ports: start, done, bcd out, ovf flag.
  - Instantiated only under the macro.

Test Plan (sim params: NUM_COLS=4, E_PULSE_CYC=2, CMD_WAIT_CYC=4, CLEAR_WAIT_CYC=8, POWERUP_CYC=20):
- Reset release → E stays 0 for 20 cycles, then bytes 38,0C,06,01 with RS=0 and E-high width exactly 2; gap after 01 is 8 cycles; init_done rises after it.
- Update line1="ABCD", line2="wxyz" → RS/DATA sequence 80,41,42,43,44,C0,77,78,79,7A; frame_done 70 cycles after accept; upd_ready then rises.
- upd_valid held high while busy, inputs changed mid-frame → frame shows the values latched at accept; second frame starts only after frame_done.
- Reset asserted during the third data byte's E pulse → E=0 the next cycle, init sequence restarts, init_done=0.
- Macro on, NUM_COLS=8, NUM_COL=5, val=7 → line-2 columns 5..7 = "  7"; val=0 → "  0"; VAL_W=10, val=1000 → "***".
- Macro off, val=123 → line 2 shown verbatim, no digits inserted.
